reg_fsr_bank: RTL
=================

Name: reg_fsr_bank

Overview:
Parametrised indirect-addressing pointer file; successor to the single 8-bit FSR register. Holds NUM_FSR pointer registers, each with a per-channel auto-modify mode: plain, post-increment, post-decrement or pre-increment. Each pointer is bus-readable and bus-writable through a tri-state data port. A separate indirect-access port drives the effective address to the register-file address mux and applies the auto-modify.

Parameters:
NUM_FSR, 4, number of pointer channels (>=1)
DATA_W, 8, bus/pointer register width
ADDR_W, 5, effective address width; ADDR_W <= DATA_W
SEL_W, derived = max(1, $clog2(NUM_FSR)), channel select width (localparam)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  asynchronous active-low reset
sel  in  SEL_W  channel for bus read/write/mode write
out_en  in  1  drive data_out with pointer[sel]
write_en  in  1  load pointer[sel] <= data_in
mode_we  in  1  load mode[sel] <= data_in[1:0]
data_in  in  DATA_W  write data
data_out  out  DATA_W  pointer[sel] when out_en=1, else all Z
acc_sel  in  SEL_W  channel used for indirect access
acc_en  in  1  indirect access strobe, one per access cycle
fsr_out  out  ADDR_W  effective address of channel acc_sel

Behaviour:
- Reset (reset_n=0, async): all pointers = 0, all modes = PLAIN. Outputs: fsr_out = 0, data_out = Z unless out_en=1 (then 0). Reset mid-access discards any pending modify.
- Modes (2 bits): 00 PLAIN, 01 POSTINC, 10 POSTDEC, 11 PREINC.
- fsr_out (combinational from registered state): PREINC and acc_en=1 -> (ptr[acc_sel][ADDR_W-1:0] + 1) mod 2^ADDR_W. Otherwise ptr[acc_sel][ADDR_W-1:0].
- Commit at clock edge when acc_en=1:
  - PLAIN: no change.
  - POSTINC and PREINC: low field +1.
  - POSTDEC: low field -1.
- Arithmetic is modulo 2^ADDR_W on bits [ADDR_W-1:0]. Bits [DATA_W-1:ADDR_W] are never altered by auto-modify. Wrap: 0x1F+1 -> 0x00 and 0x00-1 -> 0x1F (ADDR_W=5).
- Latency: bus write visible on data_out and fsr_out the cycle after the edge. Auto-modify is visible the next cycle.
- data_out reflects the pre-edge value. A read and write of the same channel in one cycle returns the old value.
- Priority per channel, same cycle: mode_we > write_en > auto-modify.
  - mode_we=1: write_en is ignored entirely that cycle (pointer is not written).
  - write_en to channel c with acc_en on c: written value wins, modify dropped. fsr_out that cycle still shows the old-based address.
- Different channels on sel and acc_sel operate independently in the same cycle.
- Out-of-range sel/acc_sel (NUM_FSR not a power of 2): writes ignored, data_out and fsr_out = 0.

Optional Feature:
Macro FSR_WRAP_FLAG_EN.
- Defined: adds output wrap_flag [NUM_FSR-1:0], one sticky bit per channel, reset 0.
  - Set when an auto-modify wraps (inc from all-ones, dec from 0).
  - Cleared by write_en or mode_we to that channel.
  - Set and clear in the same cycle: clear wins.
- Undefined: port and flag logic are absent; behaviour is otherwise identical.

Decomposition:
- Package fsr_pkg holds:
  - MODE_W=2;
  - mode constants FSR_MODE_PLAIN/POSTINC/POSTDEC/PREINC;
  - the typedef for the mode field.
- Sub-module fsr_channel: one pointer, its mode, the modify adder and the optional flag, with per-channel wr/mode_wr/acc strobes.
- reg_fsr_bank instantiates NUM_FSR fsr_channel via generate. It decodes sel/acc_sel and contains the read and fsr_out muxes plus the tri-state driver.

Test Plan:
- Reset, then out_en=1 on each sel -> data_out=0x00 and fsr_out=0 for every channel. out_en=0 -> data_out all Z.
- write_en sel=1 data 0xE3, then acc_en acc_sel=1 in PLAIN -> fsr_out=0x03; pointer stays 0xE3.
- mode POSTINC on ch2, pointer 0x1F, acc_en one cycle -> fsr_out=0x1F that cycle, then pointer=0x00 (upper bits preserved), wrap_flag[2]=1 if FSR_WRAP_FLAG_EN.
- mode PREINC on ch0, pointer 0x40, acc_en -> fsr_out=0x01 the same cycle, pointer=0x41 next. POSTDEC from 0x00 -> pointer 0x1F.
- Same cycle: write_en sel=3 data 0x10 plus acc_en acc_sel=3 POSTINC pointer 0x05 -> pointer=0x10 next. mode_we together with write_en -> only the mode changes.
- Assert reset_n=0 asynchronously between edges during a POSTINC burst -> pointers and modes 0 immediately, no modify applied at the following edge.

Source files
------------

// File: rtl/fsr_pkg.sv
// Shared definitions for the indirect-addressing pointer bank.
// Holds the auto-modify mode encoding used by every pointer channel.
package fsr_pkg;

  localparam int unsigned MODE_W = 2;

  // Auto-modify mode applied when a channel is used for an indirect access.
  typedef enum logic [MODE_W-1:0] {
    FSR_MODE_PLAIN   = 2'b00,
    FSR_MODE_POSTINC = 2'b01,
    FSR_MODE_POSTDEC = 2'b10,
    FSR_MODE_PREINC  = 2'b11
  } fsr_mode_e;

endpackage

// File: rtl/fsr_channel.sv
// One pointer channel: pointer register, its auto-modify mode, the modify
// adder and (with FSR_WRAP_FLAG_EN defined) a sticky wrap flag.
// Ports:
//   clock, reset_n - clock and asynchronous active-low reset
//   wr_i           - load pointer from wdata_i
//   mode_wr_i      - load mode from wdata_i[1:0]; overrides wr_i and acc_i
//   acc_i          - indirect access on this channel this cycle
//   wdata_i        - write data
//   ptr_o          - current pointer value
//   eff_o          - effective address (pre-incremented in PREINC during access)
//   wrap_o         - sticky wrap flag (only with FSR_WRAP_FLAG_EN)
module fsr_channel
  import fsr_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_i,
  input  logic              mode_wr_i,
  input  logic              acc_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] ptr_o,
`ifdef FSR_WRAP_FLAG_EN
  output logic              wrap_o,
`endif
  output logic [ADDR_W-1:0] eff_o
);

  logic [DATA_W-1:0] ptr_q, ptr_d;
  fsr_mode_e         mode_q, mode_d;

  logic [ADDR_W-1:0] low;
  logic [ADDR_W-1:0] low_inc;
  logic [ADDR_W-1:0] low_dec;

  // Modify arithmetic only touches the address field; upper bits ride along.
  assign low     = ptr_q[ADDR_W-1:0];
  assign low_inc = low + ADDR_W'(1);
  assign low_dec = low - ADDR_W'(1);

  always_comb begin
    ptr_d  = ptr_q;
    mode_d = mode_q;
    if (mode_wr_i) begin
      mode_d = fsr_mode_e'(wdata_i[MODE_W-1:0]);
    end else if (wr_i) begin
      ptr_d = wdata_i;
    end else if (acc_i) begin
      unique case (mode_q)
        FSR_MODE_PLAIN:                    ptr_d = ptr_q;
        FSR_MODE_POSTINC, FSR_MODE_PREINC: ptr_d[ADDR_W-1:0] = low_inc;
        FSR_MODE_POSTDEC:                  ptr_d[ADDR_W-1:0] = low_dec;
        default:                           ptr_d = ptr_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q  <= '0;
      mode_q <= FSR_MODE_PLAIN;
    end else begin
      ptr_q  <= ptr_d;
      mode_q <= mode_d;
    end
  end

  assign ptr_o = ptr_q;
  assign eff_o = (acc_i && (mode_q == FSR_MODE_PREINC)) ? low_inc : low;

`ifdef FSR_WRAP_FLAG_EN
  logic wrap_q, wrap_d;
  logic wrap_evt;

  // Only a committed modify can wrap; a bus write or mode write clears and wins.
  always_comb begin
    wrap_evt = 1'b0;
    if (acc_i) begin
      unique case (mode_q)
        FSR_MODE_POSTINC, FSR_MODE_PREINC: wrap_evt = &low;
        FSR_MODE_POSTDEC:                  wrap_evt = (low == '0);
        default:                           wrap_evt = 1'b0;
      endcase
    end
    wrap_d = (wr_i || mode_wr_i) ? 1'b0 : (wrap_q | wrap_evt);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap_o = wrap_q;
`endif

endmodule

// File: rtl/reg_fsr_bank.sv
// Parametrised indirect-addressing pointer bank: NUM_FSR pointer channels,
// each with an auto-modify mode (plain, post-inc, post-dec, pre-inc).
// Optional feature macro: FSR_WRAP_FLAG_EN adds a per-channel sticky wrap flag.
// Ports:
//   clock, reset_n - clock and asynchronous active-low reset
//   sel            - channel for bus read / pointer write / mode write
//   out_en         - drive data_out with pointer[sel], else high impedance
//   write_en       - pointer[sel] <= data_in
//   mode_we        - mode[sel] <= data_in[1:0] (pointer write suppressed)
//   data_in        - write data
//   data_out       - tri-state read data
//   acc_sel        - channel used for indirect access
//   acc_en         - indirect access strobe
//   wrap_flag      - sticky wrap flags (only with FSR_WRAP_FLAG_EN)
//   fsr_out        - effective address of channel acc_sel
module reg_fsr_bank
  import fsr_pkg::*;
#(
  parameter int unsigned NUM_FSR = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 5,
  localparam int unsigned SEL_W  = (NUM_FSR > 1) ? $clog2(NUM_FSR) : 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [SEL_W-1:0]   sel,
  input  logic               out_en,
  input  logic               write_en,
  input  logic               mode_we,
  input  logic [DATA_W-1:0]  data_in,
  output logic [DATA_W-1:0]  data_out,
  input  logic [SEL_W-1:0]   acc_sel,
  input  logic               acc_en,
`ifdef FSR_WRAP_FLAG_EN
  output logic [NUM_FSR-1:0] wrap_flag,
`endif
  output logic [ADDR_W-1:0]  fsr_out
);

  logic [NUM_FSR-1:0]             wr_c;
  logic [NUM_FSR-1:0]             mode_wr_c;
  logic [NUM_FSR-1:0]             acc_c;
  logic [NUM_FSR-1:0][DATA_W-1:0] ptr_all;
  logic [NUM_FSR-1:0][ADDR_W-1:0] eff_all;
  logic [DATA_W-1:0]              rd_data;

  for (genvar i = 0; i < NUM_FSR; i++) begin : g_chan
    // Out-of-range selects match no channel, so their writes are dropped.
    assign wr_c[i]      = write_en && (sel == SEL_W'(i));
    assign mode_wr_c[i] = mode_we && (sel == SEL_W'(i));
    assign acc_c[i]     = acc_en && (acc_sel == SEL_W'(i));

    fsr_channel #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_chan (
      .clock     (clock),
      .reset_n   (reset_n),
      .wr_i      (wr_c[i]),
      .mode_wr_i (mode_wr_c[i]),
      .acc_i     (acc_c[i]),
      .wdata_i   (data_in),
      .ptr_o     (ptr_all[i]),
`ifdef FSR_WRAP_FLAG_EN
      .wrap_o    (wrap_flag[i]),
`endif
      .eff_o     (eff_all[i])
    );
  end

  // Compare-based muxes return 0 for out-of-range selects.
  always_comb begin
    rd_data = '0;
    fsr_out = '0;
    for (int unsigned i = 0; i < NUM_FSR; i++) begin
      if (sel == SEL_W'(i)) begin
        rd_data = ptr_all[i];
      end
      if (acc_sel == SEL_W'(i)) begin
        fsr_out = eff_all[i];
      end
    end
  end

  assign data_out = out_en ? rd_data : {DATA_W{1'bz}};

endmodule
